// File: rtl/cc_uart_tx.sv
// -----------------------------------------------------------------------------
// cc_uart_tx
//   UART transmitter. Accepts one parallel word per tx_start handshake while
//   idle and serialises it as: start bit (0), DATA_BITS data bits LSB first,
//   optional parity bit, STOP_BITS stop bits (1). Every bit lasts exactly
//   CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clock cycles.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial bit rate (CLK_FREQ / BAUD_RATE must be >= 2)
//   DATA_BITS  data bits per frame, 5..8 (tx_data[DATA_BITS-1:0] is sent)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   tx_data   word to send, sampled only in the accept cycle
//   tx_start  send request, accepted only while idle
//   tx_out    serial line, idles high (registered)
//   tx_busy   high from the accept edge until the frame-end edge (registered)
//   tx_done   one-cycle pulse at frame end (registered)
// -----------------------------------------------------------------------------
module cc_uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic             tx_out_reg;
    logic             tx_busy_reg;
    logic             tx_done_reg;

    // Bits above DATA_BITS are forced to zero so they neither reach the line
    // nor contribute to the parity bit.
    logic [7:0] data_masked;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign data_masked[gi] = tx_data[gi] & (gi < DATA_BITS);
        end
    endgenerate

    // Even parity = XOR of the data bits; odd parity is its complement.
    logic parity_next;
    assign parity_next = (^data_masked) ^ (PARITY == 2);

    logic bit_end;
    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_out_reg   <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Start bit goes out directly from the accept edge.
                    if (tx_start) begin
                        shift_reg    <= data_masked;
                        parity_reg   <= parity_next;
                        state_reg    <= ST_START;
                        tx_out_reg   <= 1'b0;
                        tx_busy_reg  <= 1'b1;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                        tx_out_reg   <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            if (PARITY != 0) begin
                                state_reg  <= ST_PARITY;
                                tx_out_reg <= parity_reg;
                            end else begin
                                state_reg  <= ST_STOP;
                                tx_out_reg <= 1'b1;
                            end
                        end else begin
                            // Shift register head is the bit on the line;
                            // the next bit is the one just above it.
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            tx_out_reg  <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_STOP;
                        tx_out_reg   <= 1'b1;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_IDLE;
                            tx_busy_reg <= 1'b0;
                            tx_done_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    tx_out_reg  <= 1'b1;
                    tx_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out  = tx_out_reg;
    assign tx_busy = tx_busy_reg;
    assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_cc_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_cc_uart_tx
//   Directed bench for cc_uart_tx with CLKS_PER_BIT = 8. Five instances with
//   different frame formats share one stimulus stream:
//     u0: 8N1   u1: 8E1   u2: 8O1   u3: 8E2   u4: 5N1
//   Outputs are captured on the falling edge; capture index c is the cycle
//   that follows accept edge k + c.
// -----------------------------------------------------------------------------
module tb_cc_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [4:0] out_w;
    logic [4:0] busy_w;
    logic [4:0] done_w;

    int checks;
    int errors;

    logic [4:0] cap_out  [200];
    logic [4:0] cap_busy [200];
    logic [4:0] cap_done [200];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cc_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    cc_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    cc_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    cc_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_out(out_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
    cc_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_out(out_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a frame with data d, then record ncyc falling-edge samples.
    // After the accept, tx_data becomes d2. hold_until >= 0 keeps tx_start
    // high until that capture index; pulse_at >= 0 gives a one-cycle tx_start
    // pulse (data 0x00); rst_at >= 0 asserts rst for one cycle.
    task automatic capture(input logic [7:0] d, input logic [7:0] d2, input int ncyc,
                           input int hold_until, input int pulse_at, input int rst_at);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_out[c]  = out_w;
            cap_busy[c] = busy_w;
            cap_done[c] = done_w;
            if (c == 0) begin
                tx_data = d2;
                if (hold_until < 0) tx_start = 1'b0;
            end
            if (hold_until >= 0 && c == hold_until) tx_start = 1'b0;
            if (pulse_at >= 0 && c == pulse_at) begin
                tx_start = 1'b1;
                tx_data  = 8'h00;
            end
            if (pulse_at >= 0 && c == pulse_at + 1) tx_start = 1'b0;
            if (rst_at >= 0 && c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
        end
        tx_start = 1'b0;
    endtask

    task automatic settle();
        tx_start = 1'b0;
        repeat (110) @(negedge clk);
    endtask

    // Check one frame of instance u starting at capture index base.
    // slots[s] is the expected line level during bit slot s.
    task automatic check_frame(input int u, input int base, input int nslots,
                               input logic [15:0] slots, input string tag);
        int n;
        logic obs;
        logic bad;
        int dcnt;
        n = nslots * 8;
        for (int s = 0; s < nslots; s++) begin
            obs = slots[s];
            bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (!bad && cap_out[base + s*8 + i][u] !== slots[s]) begin
                    obs = cap_out[base + s*8 + i][u];
                    bad = 1'b1;
                end
            end
            chk($sformatf("%s_slot%0d", tag, s), 32'(obs), 32'(slots[s]));
        end
        obs = 1'b1;
        bad = 1'b0;
        for (int c = base; c < base + n; c++) begin
            if (!bad && cap_busy[c][u] !== 1'b1) begin
                obs = cap_busy[c][u];
                bad = 1'b1;
            end
        end
        chk($sformatf("%s_busy_len", tag), 32'(obs), 32'd1);
        chk($sformatf("%s_busy_end", tag), 32'(cap_busy[base + n][u]), 32'd0);
        dcnt = 0;
        for (int c = base; c < base + n; c++) if (cap_done[c][u] !== 1'b0) dcnt++;
        chk($sformatf("%s_done_early", tag), 32'(dcnt), 32'd0);
        chk($sformatf("%s_done_pulse", tag), 32'(cap_done[base + n][u]), 32'd1);
        chk($sformatf("%s_idle_line", tag), 32'(cap_out[base + n][u]), 32'd1);
    endtask

    initial begin
        int dcnt;
        logic bad;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // 1. Reset and idle behaviour.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_state%0d", i), {17'd0, out_w, busy_w, done_w}, {17'd0, 5'h1F, 5'h00, 5'h00});
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bad && {out_w, busy_w, done_w} !== {5'h1F, 5'h00, 5'h00}) begin
                bad = 1'b1;
                chk($sformatf("idle_cyc%0d", i), {17'd0, out_w, busy_w, done_w}, {17'd0, 5'h1F, 5'h00, 5'h00});
            end
        end
        chk("idle_20_cycles", 32'(bad), 32'd0);

        // 2/3. 0xA5 on all formats, with an ignored tx_start pulse at cycle 30.
        capture(8'hA5, 8'h3C, 110, -1, 30, -1);
        check_frame(0, 0, 10, 16'b1101001010, "a5_8n1");
        check_frame(1, 0, 11, 16'b10101001010, "a5_8e1");
        check_frame(2, 0, 11, 16'b11101001010, "a5_8o1");
        check_frame(3, 0, 12, 16'b110101001010, "a5_8e2");
        dcnt = 0;
        for (int c = 81; c < 110; c++) if (cap_busy[c][0] !== 1'b0 || cap_done[c][0] !== 1'b0) dcnt++;
        chk("a5_no_queued_frame", 32'(dcnt), 32'd0);
        settle();

        // 4. tx_start held high: 0x00 then 0xFF back-to-back.
        capture(8'h00, 8'hFF, 170, 161, -1, -1);
        check_frame(0, 0, 10, 16'b1000000000, "b2b_f1");
        check_frame(0, 81, 10, 16'b1111111110, "b2b_f2");
        settle();

        // 5. Reset at cycle 35 of a 0x00 frame, then a clean frame.
        capture(8'h00, 8'h00, 110, -1, -1, 34);
        chk("rst_mid_before", {30'd0, cap_out[34][0], cap_busy[34][0]}, 32'b01);
        chk("rst_mid_after", {27'd0, cap_out[35], cap_busy[35]} & 32'h3FF, {27'd0, 5'h1F, 5'h00});
        dcnt = 0;
        for (int c = 0; c < 110; c++) if (cap_done[c] !== 5'h00) dcnt++;
        chk("rst_mid_no_done", 32'(dcnt), 32'd0);
        dcnt = 0;
        for (int c = 35; c < 110; c++) if (cap_out[c] !== 5'h1F || cap_busy[c] !== 5'h00) dcnt++;
        chk("rst_mid_stays_idle", 32'(dcnt), 32'd0);
        capture(8'h00, 8'h00, 110, -1, -1, -1);
        check_frame(0, 0, 10, 16'b1000000000, "post_rst");
        settle();

        // 6. 0xFF: five data ones only on the 5-bit instance.
        capture(8'hFF, 8'h00, 110, -1, -1, -1);
        check_frame(4, 0, 7, 16'b1111110, "ff_5n1");
        check_frame(0, 0, 10, 16'b1111111110, "ff_8n1");
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
